hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, pipeline stage count (stage 0 = fetch, NUM_STAGES-1 = writeback), legal range 5..8.
REQ-002 SHALL have parameter BR_STAGE, default 2, stage index where branches resolve, legal range 2..MEM_STAGE-1.
REQ-003 SHALL have parameter MEM_STAGE, default 3, stage index of data-memory access, legal range BR_STAGE+1..NUM_STAGES-2.
REQ-004 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 if_mem_busy  input  1  instruction fetch outstanding, no response this cycle.
REQ-008 d_mem_busy  input  1  data access in MEM_STAGE outstanding.
REQ-009 id_rs1, id_rs2  input  5 each  decode-stage source registers (rv32i_reg).
REQ-010 id_uses_rs1, id_uses_rs2  input  1 each  decode instruction reads that source.
REQ-011 ex_rd  input  5  destination register of the instruction in BR_STAGE.
REQ-012 ex_valid, ex_mem_read  input  1 each  BR_STAGE instruction valid / is a load.
REQ-013 br_taken  input  1  redirect resolved in BR_STAGE this cycle.
REQ-014 wb_valid  input  1  valid instruction retiring this cycle.
REQ-015 cnt_clr  input  1  synchronous clear of all counters.
REQ-016 stage_en  output  NUM_STAGES  bit i = pipeline register feeding stage i loads this cycle.
REQ-017 stage_flush  output  NUM_STAGES  bit i = register feeding stage i loads a bubble (valid=0).
REQ-018 stall_cause  output  3  current-cycle cause, stall_cause_t.
REQ-019 cnt_cycles, cnt_retired, cnt_load_use, cnt_dmem, cnt_flush  output  CNT_W each  performance counters.

Function
REQ-020 Priority per cycle SHALL be: d_mem_busy > FLUSH_WAIT state > br_taken > load-use > if_mem_busy > none; default stage_en all 1, stage_flush all 0, stall_cause no_stall.
REQ-021 d_mem_busy: stage_en[0..MEM_STAGE]=0, stage_flush[MEM_STAGE+1]=1, later stages advance, cause mem_delay_stall; br_taken ignored this cycle (BR_STAGE frozen, re-presented later).
REQ-022 br_taken accepted: stage_flush[1..BR_STAGE]=1, cause br_flush; if if_mem_busy also high, FSM SHALL go RUN->FLUSH_WAIT.
REQ-023 FLUSH_WAIT: stage_en[0]=0, stage_flush[1]=1, cause br_flush, every cycle; on the cycle if_mem_busy is low the stale response is discarded (stage_flush[1]=1) and FSM returns to RUN next cycle.
REQ-024 Load-use: ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)) -> stage_en[0..1]=0, stage_flush[2]=1, cause read_after_load.
REQ-025 if_mem_busy in RUN: stage_en[0]=0, stage_flush[1]=1, cause imem_stall.
REQ-026 Control outputs SHALL be combinational from inputs and FSM state, zero-cycle latency; counters update at the clock edge.
REQ-027 Counters: cnt_cycles +1 every non-reset cycle; cnt_retired +1 on wb_valid; cnt_load_use +1 on REQ-024 cycles; cnt_dmem +1 on d_mem_busy cycles; cnt_flush +1 per accepted br_taken.
REQ-028 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 cnt_clr SHALL override increment; all counters 0 the following cycle.

Reset
REQ-030 While rst: stage_en all 0, stage_flush all 1, stall_cause no_stall, FSM RUN.
REQ-031 Reset SHALL zero all counters; rst asserted in FLUSH_WAIT SHALL return to RUN with no pending discard.

Structure
REQ-032 stall_cause_t (no_stall=0, read_after_load=1, mem_delay_stall=2, imem_stall=3, br_flush=4) and hazard_state_t (RUN, FLUSH_WAIT) SHALL live in rv32i_types, superseding stall_debug.
REQ-033 Counters SHALL use one sub-module, sat_counter (params WIDTH; ports clk, rst, clr, inc, count), instantiated five times.

Verification
REQ-034 Load-use: ex_rd=5, ex_mem_read=1, id_rs1=5, id_uses_rs1=1 -> stage_en=5'b11100, stage_flush=5'b00100, cause=1, cnt_load_use 0->1.
REQ-035 Mem stall: d_mem_busy=1 for 3 cycles with br_taken=1 -> stage_en=5'b10000, stage_flush=5'b10000, cnt_dmem=3, cnt_flush=0 until release.
REQ-036 Branch + fetch busy: br_taken=1, if_mem_busy=1 for 4 cycles -> FLUSH_WAIT, stage_flush[1]=1 through the response cycle, RUN after, cnt_flush=1.
REQ-037 Saturation: CNT_W=4, 20 cycles with wb_valid=1 -> cnt_retired=15; cnt_clr=1 -> 0 next cycle.
REQ-038 Reset in FLUSH_WAIT: rst one cycle -> RUN, all counters 0, stage_flush all 1 during rst.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared RV32I pipeline types: stall causes, hazard FSM states and register index type.
package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef enum logic [2:0] {
    no_stall        = 3'd0,
    read_after_load = 3'd1,
    mem_delay_stall = 3'd2,
    imem_stall      = 3'd3,
    br_flush        = 3'd4
  } stall_cause_t;

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    FLUSH_WAIT = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear overrides increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush, stall cause and performance counters.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned BR_STAGE   = 2,
  parameter int unsigned MEM_STAGE  = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_mem_busy,
  input  logic                  d_mem_busy,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [4:0]            ex_rd,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  br_taken,
  input  logic                  wb_valid,
  input  logic                  cnt_clr,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_flush,
  output logic [2:0]            stall_cause,
  output logic [CNT_W-1:0]      cnt_cycles,
  output logic [CNT_W-1:0]      cnt_retired,
  output logic [CNT_W-1:0]      cnt_load_use,
  output logic [CNT_W-1:0]      cnt_dmem,
  output logic [CNT_W-1:0]      cnt_flush
);

  localparam logic [NUM_STAGES-1:0] One         = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] HoldThruMem = (One << (MEM_STAGE + 1)) - One;
  localparam logic [NUM_STAGES-1:0] FlushPastMem = One << (MEM_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] FlushToBr   = ((One << (BR_STAGE + 1)) - One) & ~One;
  localparam logic [NUM_STAGES-1:0] FetchHold   = One;
  localparam logic [NUM_STAGES-1:0] DecodeFlush = One << 1;
  localparam logic [NUM_STAGES-1:0] LuHold      = (One << 2) - One;
  localparam logic [NUM_STAGES-1:0] LuFlush     = One << 2;

  hazard_state_t state_q, state_d;
  stall_cause_t  cause;
  logic          load_use;
  logic          lu_acc;
  logic          br_acc;
  logic          rs1_hit, rs2_hit;

  assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

  // Priority chain; a frozen branch during a data stall is re-presented once released.
  always_comb begin
    stage_en    = '1;
    stage_flush = '0;
    cause       = no_stall;
    state_d     = state_q;
    lu_acc      = 1'b0;
    br_acc      = 1'b0;
    if (rst) begin
      stage_en    = '0;
      stage_flush = '1;
      state_d     = RUN;
    end else if (d_mem_busy) begin
      stage_en    = ~HoldThruMem;
      stage_flush = FlushPastMem;
      cause       = mem_delay_stall;
    end else if (state_q == FLUSH_WAIT) begin
      // The late fetch response belongs to the wrong path and is dropped.
      stage_en    = ~FetchHold;
      stage_flush = DecodeFlush;
      cause       = br_flush;
      if (!if_mem_busy) begin
        state_d = RUN;
      end
    end else if (br_taken) begin
      stage_flush = FlushToBr;
      cause       = br_flush;
      br_acc      = 1'b1;
      if (if_mem_busy) begin
        state_d = FLUSH_WAIT;
      end
    end else if (load_use) begin
      stage_en    = ~LuHold;
      stage_flush = LuFlush;
      cause       = read_after_load;
      lu_acc      = 1'b1;
    end else if (if_mem_busy) begin
      stage_en    = ~FetchHold;
      stage_flush = DecodeFlush;
      cause       = imem_stall;
    end
  end

  assign stall_cause = cause;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt_cycles (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (1'b1),
    .count (cnt_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_retired (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (wb_valid),
    .count (cnt_retired)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_load_use (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (lu_acc),
    .count (cnt_load_use)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_dmem (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (d_mem_busy),
    .count (cnt_dmem)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (br_acc),
    .count (cnt_flush)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a 32-bit-counter instance and a 4-bit-counter instance.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst, if_mem_busy, d_mem_busy, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_mem_read, br_taken, wb_valid, cnt_clr;

  logic [4:0]  stage_en, stage_flush, en_s, fl_s;
  logic [2:0]  stall_cause, cause_s;
  logic [31:0] c_cyc, c_ret, c_lu, c_dm, c_fl;
  logic [3:0]  s_cyc, s_ret, s_lu, s_dm, s_fl;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk (clk), .rst (rst), .if_mem_busy (if_mem_busy), .d_mem_busy (d_mem_busy),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2), .ex_rd (ex_rd), .ex_valid (ex_valid),
    .ex_mem_read (ex_mem_read), .br_taken (br_taken), .wb_valid (wb_valid),
    .cnt_clr (cnt_clr), .stage_en (stage_en), .stage_flush (stage_flush),
    .stall_cause (stall_cause), .cnt_cycles (c_cyc), .cnt_retired (c_ret),
    .cnt_load_use (c_lu), .cnt_dmem (c_dm), .cnt_flush (c_fl)
  );

  hazard_ctrl #(.CNT_W(4)) dut_s (
    .clk (clk), .rst (rst), .if_mem_busy (if_mem_busy), .d_mem_busy (d_mem_busy),
    .id_rs1 (id_rs1), .id_rs2 (id_rs2), .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2), .ex_rd (ex_rd), .ex_valid (ex_valid),
    .ex_mem_read (ex_mem_read), .br_taken (br_taken), .wb_valid (wb_valid),
    .cnt_clr (cnt_clr), .stage_en (en_s), .stage_flush (fl_s),
    .stall_cause (cause_s), .cnt_cycles (s_cyc), .cnt_retired (s_ret),
    .cnt_load_use (s_lu), .cnt_dmem (s_dm), .cnt_flush (s_fl)
  );

  typedef struct packed {
    logic [4:0]  en;
    logic [4:0]  fl;
    logic [2:0]  cause;
    logic [31:0] cyc, ret, lu, dm, flc;
    logic [3:0]  ret4;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model state
  logic        m_fw = 1'b0;
  logic [31:0] m_cyc = 0, m_ret = 0, m_lu = 0, m_dm = 0, m_flc = 0;
  logic [3:0]  m_ret4 = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst = 1'b0; if_mem_busy = 1'b0; d_mem_busy = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    br_taken = 1'b0; wb_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  // One cycle: predict, push, compare at negedge, advance model at posedge.
  task automatic step();
    exp_t e, g;
    logic lu, bra, nfw, haz;
    haz = ex_valid && ex_mem_read && (ex_rd != 0) &&
          ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    e.en = 5'b11111; e.fl = 5'b00000; e.cause = 3'd0;
    lu = 1'b0; bra = 1'b0; nfw = m_fw;
    if (rst) begin
      e.en = 5'b00000; e.fl = 5'b11111; nfw = 1'b0;
    end else if (d_mem_busy) begin
      e.en = 5'b10000; e.fl = 5'b10000; e.cause = 3'd2;
    end else if (m_fw) begin
      e.en = 5'b11110; e.fl = 5'b00010; e.cause = 3'd4;
      if (!if_mem_busy) nfw = 1'b0;
    end else if (br_taken) begin
      e.fl = 5'b00110; e.cause = 3'd4; bra = 1'b1;
      if (if_mem_busy) nfw = 1'b1;
    end else if (haz) begin
      e.en = 5'b11100; e.fl = 5'b00100; e.cause = 3'd1; lu = 1'b1;
    end else if (if_mem_busy) begin
      e.en = 5'b11110; e.fl = 5'b00010; e.cause = 3'd3;
    end
    e.cyc = m_cyc; e.ret = m_ret; e.lu = m_lu; e.dm = m_dm; e.flc = m_flc; e.ret4 = m_ret4;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check_val("stage_en",    32'(stage_en),    32'(g.en));
    check_val("stage_flush", 32'(stage_flush), 32'(g.fl));
    check_val("stall_cause", 32'(stall_cause), 32'(g.cause));
    check_val("cnt_cycles",  c_cyc, g.cyc);
    check_val("cnt_retired", c_ret, g.ret);
    check_val("cnt_load_use", c_lu, g.lu);
    check_val("cnt_dmem",    c_dm,  g.dm);
    check_val("cnt_flush",   c_fl,  g.flc);
    check_val("cnt_retired_w4", 32'(s_ret), 32'(g.ret4));
    @(posedge clk);
    if (rst || cnt_clr) begin
      m_cyc = 0; m_ret = 0; m_lu = 0; m_dm = 0; m_flc = 0; m_ret4 = 0;
    end else begin
      m_cyc++;
      m_ret = m_ret + 32'(wb_valid);
      m_lu  = m_lu + 32'(lu);
      m_dm  = m_dm + 32'(d_mem_busy);
      m_flc = m_flc + 32'(bra);
      if (wb_valid && m_ret4 != 4'hf) m_ret4++;
    end
    m_fw = rst ? 1'b0 : nfw;
    #1;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) step();
    set_idle();
    repeat (3) step();

    // Load-use on rs1, on rs2, then non-hazard variants
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    step();
    id_uses_rs1 = 1'b0; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    step();
    ex_rd = 5'd0; id_rs2 = 5'd0;
    step();
    ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    step();
    id_uses_rs1 = 1'b1; ex_mem_read = 1'b0;
    step();
    set_idle();

    if_mem_busy = 1'b1;
    repeat (2) step();
    set_idle();

    // Data stall masks a pending branch, which is taken once released
    d_mem_busy = 1'b1; br_taken = 1'b1;
    repeat (3) step();
    d_mem_busy = 1'b0;
    step();
    set_idle();

    // Branch while fetch busy, then stale response discarded
    br_taken = 1'b1; if_mem_busy = 1'b1;
    repeat (4) step();
    set_idle();
    repeat (2) step();

    wb_valid = 1'b1;
    repeat (20) step();
    wb_valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    step();

    // Reset while in FLUSH_WAIT
    br_taken = 1'b1; if_mem_busy = 1'b1;
    step();
    br_taken = 1'b0; rst = 1'b1;
    step();
    set_idle();
    repeat (2) step();

    for (int i = 0; i < 80; i++) begin
      rst         = ($urandom_range(0, 19) == 0);
      cnt_clr     = ($urandom_range(0, 19) == 0);
      if_mem_busy = ($urandom_range(0, 2) == 0);
      d_mem_busy  = ($urandom_range(0, 4) == 0);
      br_taken    = ($urandom_range(0, 3) == 0);
      wb_valid    = 1'($urandom_range(0, 1));
      ex_valid    = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom_range(0, 1));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
